rtc_set_ctrl: RTL and testbench
===============================

Name: rtc_set_ctrl

Overview:
- Button-driven programming front end for the rtc block.
- Writes a new time (hour/min) into the rtc through a one-cycle load strobe.
- Owns and drives the rtc's alarm_hr, alarm_min and alarm_en inputs.
- Sits between debounced user buttons and the rtc; reads the rtc's current hour/min to seed edits.

Parameters:
- TIMEOUT_CYC, 1000: idle cycles in any edit state before aborting back to RUN.
- BLINK_DIV, 250: half-period of the blink output, in clk cycles.
- REP_DELAY, 50: hold cycles before auto-repeat starts (AUTOREP_EN only).
- REP_RATE, 10: cycles between repeated steps (AUTOREP_EN only).

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  asynchronous, active-low reset.
- btn_mode  in  1  debounced level; rising edge advances the state.
- btn_inc  in  1  debounced level; rising edge increments the field.
- btn_dec  in  1  debounced level; rising edge decrements the field.
- cur_hour  in  5  rtc hour, 0-23.
- cur_min  in  6  rtc minute, 0-59.
- set_hr  out  5  hour value presented to the rtc.
- set_min  out  6  minute value presented to the rtc.
- time_load  out  1  one-cycle pulse; rtc loads set_hr/set_min and clears sec.
- alarm_hr  out  6  committed alarm hour, 0-23.
- alarm_min  out  6  committed alarm minute, 0-59.
- alarm_en  out  1  committed alarm enable.
- edit_mode  out  3  current state encoding, for the display.
- blink  out  1  toggles every BLINK_DIV cycles while editing; 0 in RUN.

Behaviour:
- Reset (rst=0, async):
  - State = RUN; set_hr=0, set_min=0, time_load=0.
  - alarm_hr=0, alarm_min=0, alarm_en=0, blink=0.
  - All edge detectors, timers and shadows are cleared.
- Edge detection: a registered previous value per button; a press is cur&~prev. A button held through reset release does not produce a press.
- States (edit_mode encoding): RUN=0, T_HR=1, T_MIN=2, A_HR=3, A_MIN=4, A_EN=5.
- Transitions on a mode press:
  - RUN->T_HR: shadow edit_hr=cur_hour, edit_min=cur_min, captured in the same cycle.
  - T_HR->T_MIN.
  - T_MIN->A_HR: time_load=1 for exactly the next cycle, with set_hr/set_min = shadows, stable from that cycle until the next commit.
  - A_HR->A_MIN.
  - A_MIN->A_EN.
  - A_EN->RUN: alarm_hr/alarm_min/alarm_en updated from alarm shadows in the same cycle as the transition.
- On entry to A_HR, alarm shadows load from the committed alarm registers.
- Field arithmetic (one step per press, active field only):
  - Hours wrap 23->0 on inc and 0->23 on dec.
  - Minutes wrap 59->0 on inc and 0->59 on dec.
  - In A_EN, inc or dec toggles the enable shadow.
  - Presses in RUN are ignored.
- Simultaneous events:
  - Mode and inc/dec pressed in the same cycle: mode wins, the step is dropped.
  - Inc and dec pressed in the same cycle: both ignored.
- Timeout: a counter resets on any press and increments in edit states. When it reaches TIMEOUT_CYC-1, the block returns to RUN:
  - No time_load is issued.
  - Alarm outputs keep their prior values.
  - All uncommitted edits are discarded.
- Blink: counter is 0 in RUN; blink toggles on terminal count in any edit state and returns to 0 on entering RUN.
- Reset mid-edit: immediate return to RUN with reset values; the rtc sees no time_load.

Optional Feature:
- Macro AUTOREP_EN.
  - Defined: while inc or dec is held alone, the first step occurs on the edge. After REP_DELAY further cycles, one step issues every REP_RATE cycles until release. Repeat steps count as presses for the timeout.
  - Undefined: the repeat counters are not generated, and only edges step the field.

Test Plan:
- Reset with cur_hour=10, cur_min=20 -> all outputs 0, edit_mode=0, blink=0.
- Mode press with cur_hour=23, cur_min=59, then 1 inc in T_HR, mode, 1 inc in T_MIN, mode -> single time_load pulse with set_hr=0, set_min=0; edit_mode=3.
- Continue: A_HR dec x2 from 0, mode, A_MIN inc x20, mode, A_EN inc, mode -> alarm_hr=22, alarm_min=20, alarm_en=1, edit_mode=0.
- Enter T_HR, press mode and inc in the same cycle -> edit_mode=2, hour shadow unchanged; inc+dec together -> no change.
- Enter T_HR, idle TIMEOUT_CYC cycles -> edit_mode=0, time_load never asserted, alarm outputs unchanged.
- With AUTOREP_EN: hold inc in T_MIN for 1+REP_DELAY+3*REP_RATE cycles from 0 -> minute shadow=4; without the macro -> 1.

Source files
------------

// File: rtl/rtc_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// rtc_set_ctrl_if
// Groups the button inputs, rtc readback and all programming outputs of
// rtc_set_ctrl into one bundle.
//   master : the user/rtc side (drives buttons and cur_*; observes outputs)
//   slave  : rtc_set_ctrl itself
// Signals:
//   btn_mode/btn_inc/btn_dec : debounced button levels
//   cur_hour[4:0]/cur_min[5:0] : current rtc time, used to seed time edits
//   set_hr[4:0]/set_min[5:0]/time_load : time write to the rtc
//   alarm_hr[5:0]/alarm_min[5:0]/alarm_en : committed alarm settings
//   edit_mode[2:0]/blink : display hints
// ---------------------------------------------------------------------------
interface rtc_set_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic       time_load;
  logic [5:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic [2:0] edit_mode;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, btn_dec, cur_hour, cur_min,
    input  set_hr, set_min, time_load, alarm_hr, alarm_min, alarm_en,
           edit_mode, blink
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, cur_hour, cur_min,
    output set_hr, set_min, time_load, alarm_hr, alarm_min, alarm_en,
           edit_mode, blink
  );
endinterface

// File: rtl/rtc_set_ctrl.sv
// ---------------------------------------------------------------------------
// rtc_set_ctrl
// Button-driven programming front end for the rtc. A mode button walks
// RUN -> T_HR -> T_MIN -> A_HR -> A_MIN -> A_EN -> RUN; inc/dec step the
// field being edited. Leaving T_MIN writes the edited time to the rtc with a
// one-cycle time_load pulse; leaving A_EN commits the alarm settings.
// Inactivity for TIMEOUT_CYC cycles in an edit state abandons the edit.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   bus  : rtc_set_ctrl_if.slave (buttons, rtc readback, outputs)
//
// Optional feature: define AUTOREP_EN to get auto-repeat of held inc/dec
// (first step on the press, then every REP_RATE cycles once REP_DELAY
// further cycles have passed). Without it only button edges step a field.
// ---------------------------------------------------------------------------
module rtc_set_ctrl #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int BLINK_DIV   = 250,
  parameter int REP_DELAY   = 50,
  parameter int REP_RATE    = 10
) (
  input logic          clk,
  input logic          rst,
  rtc_set_ctrl_if.slave bus
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    T_HR  = 3'd1,
    T_MIN = 3'd2,
    A_HR  = 3'd3,
    A_MIN = 3'd4,
    A_EN  = 3'd5
  } state_t;

  function automatic logic [4:0] hr_step(input logic [4:0] v,
                                         input logic up, input logic dn);
    logic [4:0] r;
    r = v;
    if (up)      r = (v == 5'd23) ? 5'd0 : v + 5'd1;
    else if (dn) r = (v == 5'd0) ? 5'd23 : v - 5'd1;
    return r;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] v,
                                          input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up)      r = (v == 6'd59) ? 6'd0 : v + 6'd1;
    else if (dn) r = (v == 6'd0) ? 6'd59 : v - 6'd1;
    return r;
  endfunction

  state_t           state_q;
  logic             armed_q;
  logic             mode_prev_q, inc_prev_q, dec_prev_q;
  logic [TMO_W-1:0] tmo_q;
  logic [BLK_W-1:0] blink_cnt_q;
  logic             blink_q;
  logic [4:0]       edit_hr_q,  edit_hr_d;
  logic [5:0]       edit_min_q, edit_min_d;
  logic [4:0]       alm_hr_q,   alm_hr_d;
  logic [5:0]       alm_min_q,  alm_min_d;
  logic             alm_en_q,   alm_en_d;
  logic [4:0]       set_hr_q;
  logic [5:0]       set_min_q;
  logic             time_load_q;
  logic [5:0]       alarm_hr_q, alarm_min_q;
  logic             alarm_en_q;

  // armed_q masks the first cycle after reset so a button already held
  // when reset releases is not mistaken for a fresh press.
  logic mode_p, inc_edge, dec_edge;
  assign mode_p   = armed_q & bus.btn_mode & ~mode_prev_q;
  assign inc_edge = armed_q & bus.btn_inc  & ~inc_prev_q;
  assign dec_edge = armed_q & bus.btn_dec  & ~dec_prev_q;

  logic inc_step, dec_step;

`ifdef AUTOREP_EN
  localparam int REP_W = $clog2(REP_DELAY + REP_RATE + 1);

  logic             inc_alone, dec_alone, rep_hit;
  logic [REP_W-1:0] rep_q;
  logic             rep_run_q;

  assign inc_alone = bus.btn_inc & ~bus.btn_dec;
  assign dec_alone = bus.btn_dec & ~bus.btn_inc;

  // rep_q counts cycles since the last step; the first repeat waits
  // REP_DELAY+REP_RATE after the edge, later ones REP_RATE.
  assign rep_hit = armed_q & (inc_alone | dec_alone) & ~(inc_edge | dec_edge) &
                   (rep_q == (rep_run_q ? REP_W'(REP_RATE)
                                        : REP_W'(REP_DELAY + REP_RATE)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q     <= '0;
      rep_run_q <= 1'b0;
    end else if (!(inc_alone || dec_alone)) begin
      rep_q     <= '0;
      rep_run_q <= 1'b0;
    end else if (inc_edge || dec_edge) begin
      rep_q     <= REP_W'(1);
      rep_run_q <= 1'b0;
    end else if (rep_hit) begin
      rep_q     <= REP_W'(1);
      rep_run_q <= 1'b1;
    end else begin
      rep_q     <= rep_q + REP_W'(1);
    end
  end

  assign inc_step = (inc_edge & ~dec_edge) | (rep_hit & inc_alone);
  assign dec_step = (dec_edge & ~inc_edge) | (rep_hit & dec_alone);
`else
  assign inc_step = inc_edge & ~dec_edge;
  assign dec_step = dec_edge & ~inc_edge;
`endif

  // Any edge, even an ignored inc+dec pair, counts as user activity.
  logic any_press;
  assign any_press = mode_p | inc_edge | dec_edge | inc_step | dec_step;

  logic to_run;

  always_comb begin
    edit_hr_d  = edit_hr_q;
    edit_min_d = edit_min_q;
    alm_hr_d   = alm_hr_q;
    alm_min_d  = alm_min_q;
    alm_en_d   = alm_en_q;
    to_run     = 1'b0;
    case (state_q)
      T_HR:  edit_hr_d  = hr_step(edit_hr_q, inc_step, dec_step);
      T_MIN: edit_min_d = min_step(edit_min_q, inc_step, dec_step);
      A_HR:  alm_hr_d   = hr_step(alm_hr_q, inc_step, dec_step);
      A_MIN: alm_min_d  = min_step(alm_min_q, inc_step, dec_step);
      A_EN:  if (inc_step || dec_step) alm_en_d = ~alm_en_q;
      default: ;
    endcase
    if (state_q != RUN) begin
      if (mode_p)
        to_run = (state_q == A_EN);
      else if (!any_press && tmo_q == TMO_W'(TIMEOUT_CYC - 1))
        to_run = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      armed_q     <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      dec_prev_q  <= 1'b0;
      tmo_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      edit_hr_q   <= '0;
      edit_min_q  <= '0;
      alm_hr_q    <= '0;
      alm_min_q   <= '0;
      alm_en_q    <= 1'b0;
      set_hr_q    <= '0;
      set_min_q   <= '0;
      time_load_q <= 1'b0;
      alarm_hr_q  <= '0;
      alarm_min_q <= '0;
      alarm_en_q  <= 1'b0;
    end else begin
      armed_q     <= 1'b1;
      mode_prev_q <= bus.btn_mode;
      inc_prev_q  <= bus.btn_inc;
      dec_prev_q  <= bus.btn_dec;
      time_load_q <= 1'b0;

      if (state_q == RUN) begin
        tmo_q       <= '0;
        blink_cnt_q <= '0;
        blink_q     <= 1'b0;
        if (mode_p) begin
          state_q    <= T_HR;
          edit_hr_q  <= bus.cur_hour;
          edit_min_q <= bus.cur_min;
        end
      end else begin
        // Timeout counter: cleared by activity and on leaving edit.
        if (any_press || to_run) tmo_q <= '0;
        else                     tmo_q <= tmo_q + TMO_W'(1);

        if (to_run || blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
          blink_cnt_q <= '0;
          blink_q     <= to_run ? 1'b0 : ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BLK_W'(1);
        end

        if (mode_p) begin
          case (state_q)
            T_HR:  state_q <= T_MIN;
            T_MIN: begin
              state_q     <= A_HR;
              set_hr_q    <= edit_hr_q;
              set_min_q   <= edit_min_q;
              time_load_q <= 1'b1;
              alm_hr_q    <= alarm_hr_q[4:0];
              alm_min_q   <= alarm_min_q;
              alm_en_q    <= alarm_en_q;
            end
            A_HR:  state_q <= A_MIN;
            A_MIN: state_q <= A_EN;
            A_EN: begin
              state_q     <= RUN;
              alarm_hr_q  <= {1'b0, alm_hr_q};
              alarm_min_q <= alm_min_q;
              alarm_en_q  <= alm_en_q;
            end
            default: state_q <= RUN;
          endcase
        end else if (to_run) begin
          state_q <= RUN;
        end else begin
          edit_hr_q  <= edit_hr_d;
          edit_min_q <= edit_min_d;
          alm_hr_q   <= alm_hr_d;
          alm_min_q  <= alm_min_d;
          alm_en_q   <= alm_en_d;
        end
      end
    end
  end

  assign bus.set_hr    = set_hr_q;
  assign bus.set_min   = set_min_q;
  assign bus.time_load = time_load_q;
  assign bus.alarm_hr  = alarm_hr_q;
  assign bus.alarm_min = alarm_min_q;
  assign bus.alarm_en  = alarm_en_q;
  assign bus.edit_mode = state_q;
  assign bus.blink     = blink_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rtc_set_ctrl
// Drives button sequences into rtc_set_ctrl. Every expected time write is
// queued when the committing mode press is driven and popped when the DUT
// raises time_load; other results are compared directly after each step.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rtc_set_ctrl;

  localparam int TIMEOUT_CYC = 1000;
  localparam int BLINK_DIV   = 4;
  localparam int REP_DELAY   = 50;
  localparam int REP_RATE    = 10;
  localparam int HOLD        = 1 + REP_DELAY + 3 * REP_RATE;
`ifdef AUTOREP_EN
  localparam int HOLD_STEPS  = 4;
`else
  localparam int HOLD_STEPS  = 1;
`endif

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] mn;
  } load_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtc_set_ctrl_if bus();

  rtc_set_ctrl #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .BLINK_DIV  (BLINK_DIV),
    .REP_DELAY  (REP_DELAY),
    .REP_RATE   (REP_RATE)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  int    total = 0;
  int    bad   = 0;
  int    load_cnt = 0;
  load_t exp_q[$];

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Scoreboard: each time_load pulse must match the next queued write.
  always @(negedge clk) begin
    if (rst_n && bus.time_load === 1'b1) begin
      load_t e;
      load_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_time_load", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("set_hr", int'(bus.set_hr), int'(e.hr));
        chk("set_min", int'(bus.set_min), int'(e.mn));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    bus.btn_dec  = d;
    tick();
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    tick();
  endtask

  task automatic press_n(input logic i, input logic d, input int n);
    for (int k = 0; k < n; k++) press(1'b0, i, d);
  endtask

  task automatic push_load(input int hr, input int mn);
    load_t e;
    e.hr = 5'(hr);
    e.mn = 6'(mn);
    exp_q.push_back(e);
  endtask

  task automatic chk_alarm(input string tag, input int hr, input int mn, input int en);
    chk({tag, "_alarm_hr"}, int'(bus.alarm_hr), hr);
    chk({tag, "_alarm_min"}, int'(bus.alarm_min), mn);
    chk({tag, "_alarm_en"}, int'(bus.alarm_en), en);
  endtask

  initial begin
    int n;
    int exp_min;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    bus.cur_hour = 5'd10;
    bus.cur_min  = 6'd20;

    // Reset state
    #23;
    chk("rst_edit_mode", int'(bus.edit_mode), 0);
    chk("rst_set_hr", int'(bus.set_hr), 0);
    chk("rst_set_min", int'(bus.set_min), 0);
    chk("rst_time_load", int'(bus.time_load), 0);
    chk("rst_blink", int'(bus.blink), 0);
    chk_alarm("rst", 0, 0, 0);

    // Mode held through reset release is not a press
    bus.btn_mode = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("held_mode_no_press", int'(bus.edit_mode), 0);
    bus.btn_mode = 1'b0;
    tick();
    chk("held_mode_release", int'(bus.edit_mode), 0);

    // Time edit with wrap 23->0 and 59->0
    bus.cur_hour = 5'd23;
    bus.cur_min  = 6'd59;
    press(1'b1, 1'b0, 1'b0);
    chk("enter_t_hr", int'(bus.edit_mode), 1);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("enter_t_min", int'(bus.edit_mode), 2);
    press(1'b0, 1'b1, 1'b0);
    push_load(0, 0);
    press(1'b1, 1'b0, 1'b0);
    chk("enter_a_hr", int'(bus.edit_mode), 3);
    chk("load_cnt_1", load_cnt, 1);
    chk("set_hr_stable", int'(bus.set_hr), 0);

    // Alarm edit: 0 -> 23 -> 22, minutes 0 -> 20, enable toggled
    press_n(1'b0, 1'b1, 2);
    press(1'b1, 1'b0, 1'b0);
    chk("enter_a_min", int'(bus.edit_mode), 4);
    press_n(1'b1, 1'b0, 20);
    press(1'b1, 1'b0, 1'b0);
    chk("enter_a_en", int'(bus.edit_mode), 5);
    chk_alarm("pre_commit", 0, 0, 0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("back_run", int'(bus.edit_mode), 0);
    chk_alarm("commit", 22, 20, 1);
    chk("run_blink", int'(bus.blink), 0);

    // Simultaneous presses: mode beats inc; inc+dec ignored
    bus.cur_hour = 5'd5;
    bus.cur_min  = 6'd7;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    chk("mode_wins", int'(bus.edit_mode), 2);
    press(1'b0, 1'b1, 1'b1);
    chk("incdec_ignored_mode", int'(bus.edit_mode), 2);
    push_load(5, 7);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("simul_back_run", int'(bus.edit_mode), 0);
    chk_alarm("recommit", 22, 20, 1);
    chk("load_cnt_2", load_cnt, 2);

    // Blink and timeout
    bus.cur_hour = 5'd1;
    bus.cur_min  = 6'd2;
    press(1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("blink_before", int'(bus.blink), 0);
    tick();
    chk("blink_toggle", int'(bus.blink), 1);
    press(1'b0, 1'b1, 1'b0);
    n = 1;
    while (bus.edit_mode != 3'd0 && n < TIMEOUT_CYC + 10) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT_CYC);
    chk("timeout_run", int'(bus.edit_mode), 0);
    chk("timeout_blink", int'(bus.blink), 0);
    chk_alarm("timeout", 22, 20, 1);
    chk("timeout_no_load", load_cnt, 2);

    // Hour dec wrap, held inc, minute dec
    bus.cur_hour = 5'd0;
    bus.cur_min  = 6'd0;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b0);
    bus.btn_inc = 1'b1;
    for (int k = 0; k < HOLD; k++) tick();
    bus.btn_inc = 1'b0;
    tick();
    press_n(1'b0, 1'b1, 5);
    exp_min = (HOLD_STEPS + 60 - 5) % 60;
    push_load(23, exp_min);
    press(1'b1, 1'b0, 1'b0);
    chk("hold_enter_a_hr", int'(bus.edit_mode), 3);
    chk("set_min_after_hold", int'(bus.set_min), exp_min);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("hold_back_run", int'(bus.edit_mode), 0);
    chk_alarm("hold", 22, 20, 1);

    // Reset mid-edit
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("pre_reset_t_min", int'(bus.edit_mode), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_edit_mode", int'(bus.edit_mode), 0);
    chk("mid_rst_time_load", int'(bus.time_load), 0);
    chk_alarm("mid_rst", 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_edit_mode", int'(bus.edit_mode), 0);

    chk("load_cnt_final", load_cnt, 3);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
